// File: rtl/adc_sample_capture.sv
// rtl/adc_sample_capture.sv - ADC0831-style serial ADC capture front end
// Starts a conversion every SAMPLE_PERIOD clocks and presents the MSB-first result as a held sample.
module adc_sample_capture #(
    parameter int SIZE          = 8,
    parameter int CLK_DIV       = 16,
    parameter int SAMPLE_PERIOD = 2048
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            adc_dout,
    output logic            adc_cs_n,
    output logic            adc_sclk,
    output logic [SIZE-1:0] sample,
    output logic            sample_valid,
    output logic            null_err,
    output logic            busy
);

    localparam int PW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = $clog2(SIZE + 3);

    localparam logic [PW-1:0] PER_LAST  = PW'(SAMPLE_PERIOD - 1);
    localparam logic [HW-1:0] HALF_LAST = HW'(CLK_DIV - 1);
    localparam logic [BW-1:0] NPULSE    = BW'(SIZE + 2);

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t          state;
    logic [PW-1:0]   per_cnt;
    logic [HW-1:0]   half_cnt;
    logic [BW-1:0]   bit_cnt;
    logic [SIZE-1:0] shift;
    logic            null_flag;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            per_cnt      <= '0;
            half_cnt     <= '0;
            bit_cnt      <= '0;
            shift        <= '0;
            null_flag    <= 1'b0;
            adc_cs_n     <= 1'b1;
            adc_sclk     <= 1'b0;
            sample       <= '0;
            sample_valid <= 1'b0;
            null_err     <= 1'b0;
            busy         <= 1'b0;
        end else begin
            // Held at zero while disabled so the first enabled edge starts a conversion.
            if (!en || per_cnt == PER_LAST) begin
                per_cnt <= '0;
            end else begin
                per_cnt <= per_cnt + PW'(1);
            end

            sample_valid <= 1'b0;
            null_err     <= 1'b0;

            case (state)
                IDLE: begin
                    if (en && per_cnt == '0) begin
                        state     <= CONV;
                        adc_cs_n  <= 1'b0;
                        adc_sclk  <= 1'b0;
                        busy      <= 1'b1;
                        shift     <= '0;
                        null_flag <= 1'b0;
                        half_cnt  <= '0;
                        bit_cnt   <= '0;
                    end
                end
                CONV: begin
                    if (half_cnt != HALF_LAST) begin
                        half_cnt <= half_cnt + HW'(1);
                    end else begin
                        half_cnt <= '0;
                        adc_sclk <= ~adc_sclk;
                        if (!adc_sclk) begin
                            // Rising edge of pulse bit_cnt+1: pulse 1 settles the mux, pulse 2 is the null bit.
                            bit_cnt <= bit_cnt + BW'(1);
                            if (bit_cnt == BW'(1)) begin
                                null_flag <= adc_dout;
                            end else if (bit_cnt >= BW'(2)) begin
                                shift <= {shift[SIZE-2:0], adc_dout};
                            end
                        end else if (bit_cnt == NPULSE) begin
                            state        <= DONE;
                            adc_cs_n     <= 1'b1;
                            busy         <= 1'b0;
                            sample       <= shift;
                            sample_valid <= 1'b1;
                            null_err     <= null_flag;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_sample_capture.sv
// tb/tb_adc_sample_capture.sv - directed bench for adc_sample_capture
// A behavioural ADC shifts a settle bit, the null bit and 8 data bits, advancing on sclk falling edges.
module tb_adc_sample_capture;

    logic       clk;
    logic       rst;
    logic       en;
    logic       adc_dout;
    logic       adc_cs_n;
    logic       adc_sclk;
    logic [7:0] sample;
    logic       sample_valid;
    logic       null_err;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int last_valid = 0;

    logic       model_null = 1'b0;
    logic [7:0] model_data = 8'h00;
    int         falls      = 0;
    logic [9:0] seq;

    adc_sample_capture #(
        .SIZE(8),
        .CLK_DIV(2),
        .SAMPLE_PERIOD(64)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .adc_dout(adc_dout),
        .adc_cs_n(adc_cs_n),
        .adc_sclk(adc_sclk),
        .sample(sample),
        .sample_valid(sample_valid),
        .null_err(null_err),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ADC model: bit index advances on each sclk fall, restarts when chip select goes high.
    always @(negedge adc_sclk or posedge adc_cs_n) begin
        if (adc_cs_n) falls = 0;
        else          falls = falls + 1;
    end
    assign seq      = {1'b0, model_null, model_data};
    assign adc_dout = (falls < 10) ? seq[9 - falls] : 1'b0;

    task automatic test_reset;
        rst = 1'b1;
        en  = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (adc_cs_n !== 1'b1)  begin errors++; $display("FAIL reset_cs_n got %b expected 1", adc_cs_n); end
        checks++; if (adc_sclk !== 1'b0)  begin errors++; $display("FAIL reset_sclk got %b expected 0", adc_sclk); end
        checks++; if (sample !== 8'h00)   begin errors++; $display("FAIL reset_sample got %h expected 00", sample); end
        checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b expected 0", sample_valid); end
        checks++; if (null_err !== 1'b0)  begin errors++; $display("FAIL reset_null_err got %b expected 0", null_err); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got %b expected 0", busy); end
    endtask

    task automatic test_first_conversion;
        int   bad;
        int   rises;
        logic prev;
        logic exp_sclk;
        model_null = 1'b0;
        model_data = 8'hA5;
        rst = 1'b0;
        en  = 1'b1;
        @(negedge clk);
        checks++; if (adc_cs_n !== 1'b0) begin errors++; $display("FAIL first_cs_fall got %b expected 0", adc_cs_n); end
        checks++; if (busy !== 1'b1)     begin errors++; $display("FAIL first_busy got %b expected 1", busy); end
        bad = 0; rises = 0; prev = 1'b0;
        for (int c = 0; c <= 40; c++) begin
            if (c > 0) @(negedge clk);
            exp_sclk = (c < 40) && (((c / 2) % 2) == 1);
            if (adc_sclk !== exp_sclk || adc_cs_n !== (c >= 40) || sample_valid !== (c == 40)) bad++;
            if (adc_sclk && !prev) rises++;
            prev = adc_sclk;
        end
        last_valid = cyc;
        checks++; if (bad != 0)       begin errors++; $display("FAIL first_waveform got %0d bad cycles expected 0", bad); end
        checks++; if (rises != 10)    begin errors++; $display("FAIL first_pulses got %0d expected 10", rises); end
        checks++; if (sample !== 8'hA5) begin errors++; $display("FAIL first_sample got %h expected a5", sample); end
        checks++; if (null_err !== 1'b0) begin errors++; $display("FAIL first_null_err got %b expected 0", null_err); end
        @(negedge clk);
        checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL first_valid_width got %b expected 0", sample_valid); end
        checks++; if (sample !== 8'hA5)      begin errors++; $display("FAIL first_sample_hold got %h expected a5", sample); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] vals [3];
        bit found;
        vals[0] = 8'h00; vals[1] = 8'hFF; vals[2] = 8'h5A;
        for (int i = 0; i < 3; i++) begin
            model_data = vals[i];
            found = 1'b0;
            for (int w = 0; w < 100 && !found; w++) begin
                @(negedge clk);
                if (sample_valid === 1'b1) found = 1'b1;
            end
            checks++;
            if (!found) begin
                errors++; $display("FAIL b2b_timeout[%0d] got no strobe expected strobe within 100 cycles", i);
            end else begin
                if (cyc - last_valid != 64) begin errors++; $display("FAIL b2b_spacing[%0d] got %0d expected 64", i, cyc - last_valid); end
                checks++;
                if (sample !== vals[i]) begin errors++; $display("FAIL b2b_sample[%0d] got %h expected %h", i, sample, vals[i]); end
                last_valid = cyc;
            end
        end
    endtask

    task automatic test_null_bit;
        bit found = 1'b0;
        model_null = 1'b1;
        model_data = 8'h3C;
        for (int w = 0; w < 100 && !found; w++) begin
            @(negedge clk);
            if (sample_valid === 1'b1) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL null_timeout got no strobe expected strobe within 100 cycles");
        end else begin
            if (sample !== 8'h3C) begin errors++; $display("FAIL null_sample got %h expected 3c", sample); end
            checks++; if (null_err !== 1'b1) begin errors++; $display("FAIL null_err_pulse got %b expected 1", null_err); end
            @(negedge clk);
            checks++; if (null_err !== 1'b0) begin errors++; $display("FAIL null_err_width got %b expected 0", null_err); end
        end
        model_null = 1'b0;
    endtask

    task automatic test_en_drop;
        bit found = 1'b0;
        int c = 0;
        int lows = 0;
        model_data = 8'hC3;
        for (int w = 0; w < 100 && !found; w++) begin
            @(negedge clk);
            if (adc_cs_n === 1'b0) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL drop_start_timeout got no cs_n fall expected fall within 100 cycles");
        end else begin
            repeat (10) @(negedge clk);
            en = 1'b0;
            c = 10;
            found = 1'b0;
            for (int w = 0; w < 100 && !found; w++) begin
                @(negedge clk);
                c++;
                if (sample_valid === 1'b1) found = 1'b1;
            end
            checks++;
            if (!found) begin
                errors++; $display("FAIL drop_valid_timeout got no strobe expected strobe at cycle 40");
            end else begin
                if (c != 40) begin errors++; $display("FAIL drop_latency got %0d expected 40", c); end
                checks++; if (sample !== 8'hC3) begin errors++; $display("FAIL drop_sample got %h expected c3", sample); end
            end
            for (int w = 0; w < 200; w++) begin
                @(negedge clk);
                if (adc_cs_n !== 1'b1 || adc_sclk !== 1'b0) lows++;
            end
            checks++; if (lows != 0) begin errors++; $display("FAIL drop_idle got %0d active cycles expected 0", lows); end
            checks++; if (sample !== 8'hC3) begin errors++; $display("FAIL drop_sample_hold got %h expected c3", sample); end
        end
    endtask

    task automatic test_rst_mid;
        int   bad;
        int   rises;
        logic prev;
        logic exp_sclk;
        model_data = 8'h96;
        en = 1'b1;
        @(negedge clk);
        checks++; if (adc_cs_n !== 1'b0) begin errors++; $display("FAIL rst_start got %b expected 0", adc_cs_n); end
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (adc_cs_n !== 1'b1) begin errors++; $display("FAIL rst_cs_n got %b expected 1", adc_cs_n); end
        checks++; if (adc_sclk !== 1'b0) begin errors++; $display("FAIL rst_sclk got %b expected 0", adc_sclk); end
        checks++; if (sample !== 8'h00)  begin errors++; $display("FAIL rst_sample got %h expected 00", sample); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL rst_busy got %b expected 0", busy); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (adc_cs_n !== 1'b0) begin errors++; $display("FAIL rst_restart got %b expected 0", adc_cs_n); end
        bad = 0; rises = 0; prev = 1'b0;
        for (int c = 0; c <= 40; c++) begin
            if (c > 0) @(negedge clk);
            exp_sclk = (c < 40) && (((c / 2) % 2) == 1);
            if (adc_sclk !== exp_sclk || adc_cs_n !== (c >= 40) || sample_valid !== (c == 40)) bad++;
            if (adc_sclk && !prev) rises++;
            prev = adc_sclk;
        end
        checks++; if (bad != 0)         begin errors++; $display("FAIL rst_waveform got %0d bad cycles expected 0", bad); end
        checks++; if (rises != 10)      begin errors++; $display("FAIL rst_pulses got %0d expected 10", rises); end
        checks++; if (sample !== 8'h96) begin errors++; $display("FAIL rst_sample_after got %h expected 96", sample); end
    endtask

    task automatic test_free_run;
        int sclk_bad = 0;
        int busy_bad = 0;
        int strobes  = 0;
        en = 1'b1;
        for (int w = 0; w < 1000; w++) begin
            @(negedge clk);
            if (adc_sclk === 1'b1 && adc_cs_n === 1'b1) sclk_bad++;
            if (busy !== ~adc_cs_n) busy_bad++;
            if (sample_valid === 1'b1) strobes++;
        end
        checks++; if (sclk_bad != 0) begin errors++; $display("FAIL free_sclk_idle got %0d cycles expected 0", sclk_bad); end
        checks++; if (busy_bad != 0) begin errors++; $display("FAIL free_busy got %0d cycles expected 0", busy_bad); end
        checks++; if (strobes < 15 || strobes > 16) begin errors++; $display("FAIL free_strobes got %0d expected 15..16", strobes); end
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        test_reset();
        test_first_conversion();
        test_back_to_back();
        test_null_bit();
        test_en_drop();
        test_rst_mid();
        test_free_run();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
